fixed_point_shift_add_multiplier: RTL and testbench

//  Sequential unsigned fixed-point multiplier: the forward companion to the

---
 rtl/fixed_point_shift_add_multiplier_pkg.sv | 16 +
 rtl/fxp_trunc_sat.sv | 25 ++
 rtl/fixed_point_shift_add_multiplier.sv | 112 +++++++++++
 tb/tb_fixed_point_shift_add_multiplier.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_shift_add_multiplier_pkg.sv
// Shared definitions for the fixed-point shift-and-add multiplier.
//   state_t     : FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   count_width : width of the iteration counter, wide enough to hold DATA_WIDTH
package fixed_point_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int count_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/fxp_trunc_sat.sv
// Combinational truncate-and-saturate stage for a 2*DATA_WIDTH-bit unsigned
// fixed-point product. Drops FRAC_BITS fractional bits (toward zero), then
// clamps to all ones when the integer part no longer fits in DATA_WIDTH bits.
// Ports:
//   full_i      2*DATA_WIDTH  exact product
//   data_o      DATA_WIDTH    truncated (or saturated) result
//   overflow_o  1             result was saturated
module fxp_trunc_sat #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic [2*DATA_WIDTH-1:0] full_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    overflow_o
);

    logic [2*DATA_WIDTH-1:0] q_shift;

    // The shift zero-fills from the top, so checking the whole upper half is
    // equivalent to checking only the bits that survive the shift.
    assign q_shift    = full_i >> FRAC_BITS;
    assign overflow_o = |q_shift[2*DATA_WIDTH-1:DATA_WIDTH];
    assign data_o     = overflow_o ? {DATA_WIDTH{1'b1}} : q_shift[DATA_WIDTH-1:0];

endmodule

// File: rtl/fixed_point_shift_add_multiplier.sv
// Sequential unsigned fixed-point multiplier, radix-2 shift-and-add.
// One operand pair is accepted in IDLE, multiplied over DATA_WIDTH BUSY
// iterations plus one finalize cycle that registers the truncated/saturated
// result, then held in DONE until the downstream handshake.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_valid, o_ready    operand handshake (o_ready high only in IDLE)
//   i_a, i_b            unsigned Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS operands
//   o_valid, i_ready    result handshake
//   o_data, o_overflow  product in the same Q format, saturation flag
module fixed_point_shift_add_multiplier
    import fixed_point_shift_add_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overflow
);

    localparam int CNT_W = count_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    state_t                  state_q;
    logic [2*DATA_WIDTH-1:0] a_sh_q;
    logic [DATA_WIDTH-1:0]   b_sh_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]        count_q;
    logic                    o_valid_q;
    logic [DATA_WIDTH-1:0]   o_data_q;
    logic                    o_overflow_q;

    logic [DATA_WIDTH-1:0]   sat_data;
    logic                    sat_ovf;

    // Partial-product add for the current multiplier bit.
    assign acc_d = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    fxp_trunc_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_trunc_sat (
        .full_i     (acc_q),
        .data_o     (sat_data),
        .overflow_o (sat_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        a_sh_q  <= {{DATA_WIDTH{1'b0}}, i_a};
                        b_sh_q  <= i_b;
                        acc_q   <= '0;
                        count_q <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // All DATA_WIDTH iterations run regardless of operand
                    // values; the extra cycle at the end registers the result
                    // from the fully accumulated product.
                    if (count_q == CNT_LAST) begin
                        o_data_q     <= sat_data;
                        o_overflow_q <= sat_ovf;
                        o_valid_q    <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        acc_q   <= acc_d;
                        a_sh_q  <= a_sh_q << 1;
                        b_sh_q  <= b_sh_q >> 1;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_overflow = o_overflow_q;

endmodule

// File: tb/tb_fixed_point_shift_add_multiplier.sv
module tb_fixed_point_shift_add_multiplier;

    localparam int DW = 8;
    localparam int FB = 4;
    localparam int LAT = DW + 1;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_a;
    logic [DW-1:0] i_b;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_overflow;

    int tests = 0;
    int fails = 0;

    fixed_point_shift_add_multiplier #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_data;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [9];

    // Reference: exact product, drop fractional bits, clamp to DW bits.
    function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned full;
        longint unsigned q;
        full = longint'(a) * longint'(b);
        q    = full / (64'd1 << FB);
        if (q > ((64'd1 << DW) - 1))
            return {1'b1, {DW{1'b1}}};
        return {1'b0, q[DW-1:0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Issue one operation; if hold is set, i_ready stays low and the result
    // is left pending in DONE.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold,
                          output logic [DW-1:0] d, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!o_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_wait: o_ready never rose within 100 cycles");
        end
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_ready = !hold;
        tick();
        i_valid = 1'b0;
        // Scramble operands after acceptance; the in-flight result must not care.
        i_a = DW'($urandom);
        i_b = DW'($urandom);
        lat = 0;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        d  = o_data;
        ov = o_overflow;
        if (!hold) tick();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          ov;
        int            lat;
        logic [DW:0]   m;

        vecs[0] = '{8'h20, 8'h18, 8'h30, 1'b0};
        vecs[1] = '{8'hF0, 8'h20, 8'hFF, 1'b1};
        vecs[2] = '{8'h01, 8'h01, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{8'h10, 8'h10, 8'h10, 1'b0};
        vecs[6] = '{8'h3F, 8'h40, 8'hFC, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 8'hFF, 1'b1};
        vecs[8] = '{8'h0F, 8'h11, 8'h0F, 1'b0};

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        tick();
        tick();
        i_reset = 1'b0;
        check("reset_valid", int'(o_valid), 0);
        check("reset_data", int'(o_data), 0);
        check("reset_ovf", int'(o_overflow), 0);
        check("reset_ready", int'(o_ready), 1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, d, ov, lat);
            $display("[TB] vec %0d a=%02h b=%02h -> data=%02h ovf=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, d, ov, lat);
            check($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_ovf", i), int'(ov), int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i), lat, LAT);
            check($sformatf("vec%0d_idle", i), int'({o_valid, o_ready}), 1);
        end

        // Backpressure: result frozen, new operands ignored while DONE
        run_op(8'h30, 8'h30, 1'b1, d, ov, lat);
        $display("[TB] backpressure a=30 b=30 -> data=%02h ovf=%0d lat=%0d", d, ov, lat);
        check("bp_data", int'(d), 8'h90);
        check("bp_lat", lat, LAT);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                i_valid = 1'b1;
                i_a     = 8'hFF;
                i_b     = 8'hFF;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            check($sformatf("bp_hold%0d_valid", c), int'(o_valid), 1);
            check($sformatf("bp_hold%0d_data", c), int'(o_data), 8'h90);
            check($sformatf("bp_hold%0d_ovf", c), int'(o_overflow), 0);
            check($sformatf("bp_hold%0d_ready", c), int'(o_ready), 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(o_valid), 0);
        check("bp_release_ready", int'(o_ready), 1);
        for (int c = 0; c < 12; c++) tick();
        check("bp_not_queued", int'({o_valid, o_ready}), 1);

        // Reset during BUSY iteration 3
        i_valid = 1'b1;
        i_a     = 8'hF0;
        i_b     = 8'h20;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        $display("[TB] reset mid-op -> valid=%0d data=%02h ready=%0d", o_valid, o_data, o_ready);
        check("rst_mid_valid", int'(o_valid), 0);
        check("rst_mid_data", int'(o_data), 0);
        check("rst_mid_ovf", int'(o_overflow), 0);
        check("rst_mid_ready", int'(o_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (o_valid) seen = 1;
            end
            check("rst_mid_no_result", seen, 0);
        end
        run_op(8'h10, 8'h10, 1'b0, d, ov, lat);
        $display("[TB] post-reset a=10 b=10 -> data=%02h ovf=%0d lat=%0d", d, ov, lat);
        check("rst_after_data", int'(d), 8'h10);
        check("rst_after_lat", lat, LAT);

        // Random operands against the reference model, with random stalls
        for (int r = 0; r < 40; r++) begin
            logic [DW-1:0] ra;
            logic [DW-1:0] rb;
            int            stall;
            ra    = DW'($urandom);
            rb    = DW'($urandom);
            stall = $urandom_range(0, 3);
            m     = model(ra, rb);
            run_op(ra, rb, 1'b1, d, ov, lat);
            $display("[TB] rand %0d a=%02h b=%02h -> data=%02h ovf=%0d stall=%0d",
                     r, ra, rb, d, ov, stall);
            check($sformatf("rand%0d_data", r), int'(d), int'(m[DW-1:0]));
            check($sformatf("rand%0d_ovf", r), int'(ov), int'(m[DW]));
            check($sformatf("rand%0d_lat", r), lat, LAT);
            for (int s = 0; s < stall; s++) begin
                tick();
                check($sformatf("rand%0d_stable", r), int'({o_valid, o_data}), int'({1'b1, d}));
            end
            i_ready = 1'b1;
            tick();
            check($sformatf("rand%0d_release", r), int'(o_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
